// File: rtl/block_memory_ctrl.sv
// Memory-side block engine: services cache line fills (reads) and dirty evictions (writes) as byte bursts.
// Latency: request to first beat is LATENCY+1 cycles, then BLOCK_BYTES beats and one DONE cycle.
// Backpressure: ready_memory is low during the access wait; the DONE state holds until both enables are low.
// Optional feature: define CRITICAL_BYTE_FIRST_EN so read bursts start at the requested byte and wrap.
module block_memory_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int LATENCY     = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              addr_mem,
  inout  wire  [DATA_W-1:0]              data_mem,
  input  logic                           read_mem_enable,
  input  logic                           write_mem_enable,
  output logic                           ready_memory,
  output logic                           beat_valid,
  output logic [$clog2(BLOCK_BYTES)-1:0] beat_index
);

  localparam int                OFF_W     = $clog2(BLOCK_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BLOCK_BYTES - 1);
  localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(BLOCK_BYTES - 1);
  localparam logic [15:0]       WAIT_LAST = 16'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD_BURST,
    S_WR_BURST,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic                accept_wr;
  logic                op_write;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   beat_addr;
  logic [OFF_W-1:0]    beat_cnt;
  logic [OFF_W-1:0]    start_off;
  logic [15:0]         wait_cnt;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  // State register; reset aborts any access or burst immediately
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; write wins a simultaneous request so the eviction precedes the fill
  always_comb begin
    state_nxt    = state;
    ready_memory = 1'b1;
    beat_valid   = 1'b0;
    accept       = 1'b0;
    accept_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (write_mem_enable) begin
          accept    = 1'b1;
          accept_wr = 1'b1;
          state_nxt = (LATENCY == 0) ? S_WR_BURST : S_WAIT;
        end else if (read_mem_enable) begin
          accept    = 1'b1;
          state_nxt = (LATENCY == 0) ? S_RD_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        ready_memory = 1'b0;
        if (wait_cnt == WAIT_LAST) state_nxt = op_write ? S_WR_BURST : S_RD_BURST;
      end
      S_RD_BURST, S_WR_BURST: begin
        beat_valid = 1'b1;
        if (beat_cnt == LAST_BEAT) state_nxt = S_DONE;
      end
      S_DONE: begin
        // Held enables must drop before a new request is taken, so a level request never retriggers
        if (!read_mem_enable && !write_mem_enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // First beat offset: writebacks always start at byte 0
  always_comb begin
`ifdef CRITICAL_BYTE_FIRST_EN
    start_off = accept_wr ? '0 : addr_mem[OFF_W-1:0];
`else
    start_off = '0;
`endif
  end

  // Request latch, access-wait counter and beat counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_write   <= 1'b0;
      base_addr  <= '0;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      beat_index <= '0;
    end else if (accept) begin
      op_write   <= accept_wr;
      base_addr  <= addr_mem & ~OFF_MASK;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      beat_index <= start_off;
    end else begin
      if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (beat_valid) begin
        // Offset wraps inside the block; the base is never incremented
        beat_index <= beat_index + 1'b1;
        beat_cnt   <= beat_cnt + 1'b1;
      end
    end
  end

  // Base is block-aligned, so the sum stays within the block and never carries into the base
  assign beat_addr = base_addr + ADDR_W'(beat_index);

  // Backing store write port; contents survive reset, bytes written before an abort stay written
  always_ff @(posedge clock) begin
    if (reset && state == S_WR_BURST) mem[beat_addr] <= data_mem;
  end

  // Shared bus is driven only while returning read data
  assign data_mem = (state == S_RD_BURST) ? mem[beat_addr] : 'z;

endmodule
